// File: rtl/clk_meter.sv
// clk_meter: measures period, high time and duty cycle of an asynchronous signal
module clk_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [6:0]       duty,
  output logic             valid,
  output logic             stuck,
  output logic             ovr
);
  localparam int NW = CNT_W + 7;
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
  state_t           r_state, w_state;
  logic             r_s1, r_s2, r_s3;
  logic             w_rise, w_fall, w_done, w_tmo, w_sclr, w_ge;
  logic [CNT_W-1:0] r_pcnt, w_pcnt, r_hcnt, w_hcnt;
  logic [CNT_W-1:0] r_dp, r_dh, r_period, r_high;
  logic [NW-1:0]    r_num, r_dsh;
  logic [5:0]       r_q;
  logic [6:0]       w_q, r_duty;
  logic [2:0]       r_step;
  logic             r_busy, r_valid, r_stuck, r_ovr;
  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_ge      = r_num >= r_dsh;
  assign w_q       = {r_q, w_ge};
  assign period    = r_period;
  assign high_time = r_high;
  assign duty      = r_duty;
  assign valid     = r_valid;
  assign stuck     = r_stuck;
  assign ovr       = r_ovr;
  // two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge clk)
    if (rst) {r_s3, r_s2, r_s1} <= 3'b000;
    else     {r_s3, r_s2, r_s1} <= {r_s2, r_s1, sig};
  // measurement state and counters
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_pcnt  <= w_pcnt;
      r_hcnt  <= w_hcnt;
    end
  // next-state: timeout wins over edges so pcnt never passes TIMEOUT
  always_comb begin
    w_state = r_state;
    w_pcnt  = r_pcnt;
    w_hcnt  = r_hcnt;
    w_done  = 1'b0;
    w_tmo   = 1'b0;
    w_sclr  = 1'b0;
    if (!en) begin
      w_state = IDLE;
      w_pcnt  = '0;
      w_hcnt  = '0;
    end else case (r_state)
      IDLE: begin
        w_state = ARM;
        w_pcnt  = '0;
        w_hcnt  = '0;
      end
      ARM: if (w_rise) begin
        w_state = HIGH;
        w_pcnt  = CNT_W'(1);
        w_sclr  = 1'b1;
      end
      HIGH: if (r_pcnt == CNT_W'(TIMEOUT)) begin
        w_tmo   = 1'b1;
        w_state = ARM;
      end else if (w_fall) begin
        w_hcnt  = r_pcnt;
        w_pcnt  = r_pcnt + 1'b1;
        w_state = LOW;
      end else w_pcnt = r_pcnt + 1'b1;
      LOW: if (r_pcnt == CNT_W'(TIMEOUT)) begin
        w_tmo   = 1'b1;
        w_state = ARM;
      end else if (w_rise) begin
        w_done  = 1'b1;
        w_pcnt  = CNT_W'(1);
        w_state = HIGH;
      end else w_pcnt = r_pcnt + 1'b1;
    endcase
  end
  // restoring divider for duty, result registers and status flags
  always_ff @(posedge clk)
    if (rst) begin
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_stuck  <= 1'b0;
      r_ovr    <= 1'b0;
      r_period <= '0;
      r_high   <= '0;
      r_duty   <= '0;
      r_num    <= '0;
      r_dsh    <= '0;
      r_dp     <= '0;
      r_dh     <= '0;
      r_q      <= '0;
      r_step   <= '0;
    end else begin
      r_valid <= 1'b0;
      if (!en) begin
        r_busy  <= 1'b0;
        r_stuck <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        if (w_tmo) r_stuck <= 1'b1;
        else if (w_sclr) r_stuck <= 1'b0;
        if (w_done && r_busy) r_ovr <= 1'b1;
        if (w_done && !r_busy) begin
          r_busy <= 1'b1;
          r_step <= '0;
          r_q    <= '0;
          r_num  <= NW'(r_hcnt) * NW'(100);
          r_dsh  <= {1'b0, r_pcnt, 6'b0};
          r_dp   <= r_pcnt;
          r_dh   <= r_hcnt;
        end else if (r_busy) begin
          r_num  <= w_ge ? r_num - r_dsh : r_num;
          r_dsh  <= r_dsh >> 1;
          r_q    <= w_q[5:0];
          r_step <= r_step + 1'b1;
          if (r_step == 3'd6) begin
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
            r_period <= r_dp;
            r_high   <= r_dh;
            r_duty   <= w_q;
          end
        end
      end
    end
endmodule

// File: tb/tb_clk_meter.sv
// tb_clk_meter: table, directed and random checks of clk_meter against a timestamp model
module tb_clk_meter;
  localparam int W  = 16;
  localparam int TO = 50000;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sig = 1'b0;
  logic [W-1:0] period, high_time;
  logic [6:0] duty;
  logic valid, stuck, ovr;
  clk_meter #(.CNT_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .sig(sig), .period(period), .high_time(high_time),
    .duty(duty), .valid(valid), .stuck(stuck), .ovr(ovr)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  typedef struct {int due; int p; int h; int d;} res_t;
  res_t pq[$];
  int cyc = 0, mode = 0, t_r = 0, t_f = 0, free_at = 0;
  bit m1, m2, m3;
  logic [W-1:0] e_p = '0, e_h = '0;
  logic [6:0] e_d = '0;
  bit e_v, e_s, e_o;
  // reference model: edges as timestamps, results as a due-cycle queue
  initial forever begin
    bit r, f;
    int p, h;
    @(posedge clk);
    r = m2 & ~m3;
    f = ~m2 & m3;
    e_v = 1'b0;
    if (rst) begin
      mode = 0; pq.delete(); free_at = 0;
      e_p = '0; e_h = '0; e_d = '0; e_s = 0; e_o = 0;
    end else if (!en) begin
      mode = 0; pq.delete(); free_at = 0; e_s = 0; e_o = 0;
    end else begin
      if (pq.size() > 0 && pq[0].due == cyc + 1) begin
        e_p = W'(pq[0].p); e_h = W'(pq[0].h); e_d = 7'(pq[0].d); e_v = 1'b1;
        void'(pq.pop_front());
      end
      if (mode == 0) mode = 1;
      else if (mode == 1) begin
        if (r) begin mode = 2; t_r = cyc; e_s = 0; end
      end else if (cyc - t_r == TO) begin
        e_s = 1; mode = 1;
      end else if (mode == 2 && f) begin
        t_f = cyc; mode = 3;
      end else if (mode == 3 && r) begin
        p = cyc - t_r;
        h = t_f - t_r;
        if (cyc < free_at) e_o = 1;
        else begin
          pq.push_back('{cyc + 8, p, h, (100 * h) / p});
          free_at = cyc + 8;
        end
        t_r = cyc; mode = 2;
      end
    end
    m3 = rst ? 1'b0 : m2;
    m2 = rst ? 1'b0 : m1;
    m1 = rst ? 1'b0 : sig;
    cyc++;
  end
  int nvalid = 0;
  logic [W-1:0] last_p = '0, last_h = '0;
  logic [6:0] last_d = '0;
  // cycle-by-cycle comparison of every output against the model
  always @(negedge clk) if (cyc > 0) begin
    check("cycle", {22'd0, period, high_time, duty, valid, stuck, ovr},
          {22'd0, e_p, e_h, e_d, e_v, e_s, e_o});
    if (valid === 1'b1) begin
      nvalid++; last_p = period; last_h = high_time; last_d = duty;
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic per(int h, int l);
    sig = 1'b1; tick(h); sig = 1'b0; tick(l);
  endtask
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sig = 1'b0; tick(2); rst = 1'b0;
  endtask
  task automatic chk_zero(string nm);
    check(nm, {period, high_time, duty, valid, stuck, ovr}, 0);
  endtask
  typedef struct {int h; int l; int p; int hi; int d; bit o;} vec_t;
  vec_t tbl[9];
  initial begin
    int nv;
    tbl[0] = '{5, 5, 10, 5, 50, 0};
    tbl[1] = '{3, 7, 10, 3, 30, 0};
    tbl[2] = '{1, 2, 3, 1, 33, 1};
    tbl[3] = '{4, 4, 8, 4, 50, 0};
    tbl[4] = '{1, 1, 2, 1, 50, 1};
    tbl[5] = '{9, 1, 10, 9, 90, 0};
    tbl[6] = '{1, 99, 100, 1, 1, 0};
    tbl[7] = '{2, 5, 7, 2, 28, 1};
    tbl[8] = '{6, 7, 13, 6, 46, 0};
    tick(1);
    do_reset();
    chk_zero("reset");
    for (int i = 0; i < 9; i++) begin
      do_reset();
      en = 1'b1; tick(4);
      nv = nvalid;
      repeat (6) per(tbl[i].h, tbl[i].l);
      tick(12);
      check("tbl_seen", nvalid > nv, 1);
      check("tbl_period", last_p, tbl[i].p);
      check("tbl_high", last_h, tbl[i].hi);
      check("tbl_duty", last_d, tbl[i].d);
      check("tbl_ovr", ovr, tbl[i].o);
    end
    do_reset();
    en = 1'b1; tick(4);
    nv = nvalid;
    sig = 1'b1; tick(4); sig = 1'b0; tick(50010);
    check("to_stuck", stuck, 1);
    check("to_novalid", nvalid, nv);
    per(4, 4);
    check("to_clear", stuck, 0);
    per(4, 4); tick(12);
    check("to_valid", nvalid, nv + 1);
    check("to_duty", last_d, 50);
    check("to_period", last_p, 8);
    do_reset();
    en = 1'b1; tick(4);
    repeat (3) per(5, 5);
    sig = 1'b1; tick(5);
    nv = nvalid;
    en = 1'b0; tick(3); sig = 1'b0; tick(15);
    check("en_novalid", nvalid, nv);
    check("en_hold", {period, high_time, duty}, {16'd10, 16'd5, 7'd50});
    check("en_flags", {stuck, ovr}, 0);
    en = 1'b1; tick(2);
    per(5, 5); tick(12);
    check("en_first", nvalid, nv);
    per(5, 5); tick(12);
    check("en_second", nvalid, nv + 1);
    do_reset();
    en = 1'b1; tick(4);
    repeat (3) per(5, 5);
    sig = 1'b1; tick(3);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk_zero("rst_high");
    tick(2); sig = 1'b0; tick(5);
    repeat (2) per(5, 5);
    sig = 1'b1; tick(5);
    nv = nvalid;
    rst = 1'b1; tick(1); rst = 1'b0;
    chk_zero("rst_div");
    sig = 1'b0; tick(15);
    check("rst_novalid", nvalid, nv);
    repeat (3) per(5, 5); tick(12);
    check("rst_restart", last_p, 10);
    do_reset();
    en = 1'b1; tick(3);
    repeat (80) begin
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0; tick($urandom_range(1, 5)); en = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1; tick(1); rst = 1'b0;
      end
      per($urandom_range(1, 12), $urandom_range(1, 12));
    end
    tick(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
